// File: rtl/rng_histogram_if.sv
// rng_histogram_if: control, sample stream and dump read port of the histogram block
interface rng_histogram_if #(parameter int BY = 8, parameter int HB = 4, parameter int CW = 16, parameter int SW = 16);
  logic start;
  logic [SW-1:0] num_samples;
  logic [BY-1:0] sample;
  logic sample_valid;
  logic busy;
  logic done;
  logic overflow;
  logic [HB-1:0] rd_bin;
  logic [CW-1:0] rd_count;
  logic rd_valid;
  logic rd_ready;
  modport master (
    output start, num_samples, sample, sample_valid, rd_ready,
    input busy, done, overflow, rd_bin, rd_count, rd_valid
  );
  modport slave (
    input start, num_samples, sample, sample_valid, rd_ready,
    output busy, done, overflow, rd_bin, rd_count, rd_valid
  );
endinterface

// File: rtl/rng_histogram.sv
// rng_histogram: bins a programmed number of rng samples into 2^HB saturating counters and dumps them
module rng_histogram #(
  parameter int BY = 8,
  parameter int HB = 4,
  parameter int CW = 16,
  parameter int SW = 16
) (
  input logic clk,
  input logic rst,
  rng_histogram_if.slave h
);
  localparam int NB = 1 << HB;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COLLECT, S_DUMP, S_FIN} state_t;
  state_t st;
  logic [CW-1:0] cnt [NB];
  logic [HB-1:0] bin, idx, nb;
  logic [SW-1:0] rem;
  logic sat;
  logic [CW-1:0] nxt;
  assign bin = h.sample[BY-1 -: HB];
  assign sat = &cnt[bin];
  assign nxt = sat ? cnt[bin] : cnt[bin] + 1'b1;
  assign nb = h.rd_bin + 1'b1;
  // rd_count is registered, so the dump entry for bin 0 must fold in the final increment
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      h.busy <= 1'b0;
      h.done <= 1'b0;
      h.overflow <= 1'b0;
      h.rd_valid <= 1'b0;
      h.rd_bin <= '0;
      h.rd_count <= '0;
      idx <= '0;
      rem <= '0;
    end else begin
      h.done <= 1'b0;
      case (st)
        S_IDLE: if (h.start) begin
          st <= S_CLEAR;
          h.busy <= 1'b1;
          h.overflow <= 1'b0;
          rem <= h.num_samples;
          idx <= '0;
        end
        S_CLEAR: begin
          cnt[idx] <= '0;
          idx <= idx + 1'b1;
          if (&idx) begin
            st <= (rem == '0) ? S_DUMP : S_COLLECT;
            h.rd_valid <= (rem == '0);
            h.rd_bin <= '0;
            h.rd_count <= '0;
          end
        end
        S_COLLECT: if (h.sample_valid) begin
          cnt[bin] <= nxt;
          rem <= rem - 1'b1;
          if (sat) h.overflow <= 1'b1;
          if (rem == SW'(1)) begin
            st <= S_DUMP;
            h.rd_valid <= 1'b1;
            h.rd_bin <= '0;
            h.rd_count <= (bin == '0) ? nxt : cnt[0];
          end
        end
        S_DUMP: if (h.rd_ready) begin
          h.rd_bin <= nb;
          h.rd_count <= cnt[nb];
          if (&h.rd_bin) begin
            st <= S_FIN;
            h.rd_valid <= 1'b0;
            h.busy <= 1'b0;
            h.done <= 1'b1;
          end
        end
        S_FIN: st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rng_histogram.sv
// tb_rng_histogram: scoreboard bench for rng_histogram with CW=4 so saturation is reachable
module tb_rng_histogram;
  localparam int BY = 8, HB = 4, CW = 4, SW = 16, NB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rng_histogram_if #(.BY(BY), .HB(HB), .CW(CW), .SW(SW)) h();
  rng_histogram #(.BY(BY), .HB(HB), .CW(CW), .SW(SW)) dut (.clk(clk), .rst(rst), .h(h));
  int n_cmp = 0;
  int n_err = 0;
  logic [HB+CW-1:0] sb [$];
  logic [BY-1:0] q [$];

  task automatic drive_idle();
    h.start = 1'b0;
    h.num_samples = '0;
    h.sample = '0;
    h.sample_valid = 1'b0;
    h.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      h.start = 1'($urandom);
      h.num_samples = SW'($urandom);
      h.sample = BY'($urandom);
      h.sample_valid = 1'($urandom);
      h.rd_ready = 1'($urandom);
    end
    @(negedge clk);
    n_cmp++; if (h.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", h.busy); end
    n_cmp++; if (h.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", h.done); end
    n_cmp++; if (h.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", h.overflow); end
    n_cmp++; if (h.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", h.rd_valid); end
    n_cmp++; if (h.rd_bin !== '0) begin n_err++; $display("FAIL reset_rd_bin got %0d want 0", h.rd_bin); end
    n_cmp++; if (h.rd_count !== '0) begin n_err++; $display("FAIL reset_rd_count got %0d want 0", h.rd_count); end
    rst = 1'b0;
    drive_idle();
  endtask

  // Full run: start, 16 CLEAR cycles fed with junk valids, samples, dump checked against the model
  task automatic do_run(input string nm, input int num, input logic [BY-1:0] smp [$], input bit bp, input bit poke);
    int m [NB];
    bit ovf;
    bit held;
    int k;
    int bud;
    logic [HB-1:0] hb;
    logic [CW-1:0] hc;
    logic [HB+CW-1:0] e;
    logic [HB-1:0] b;
    foreach (m[i]) m[i] = 0;
    ovf = 1'b0;
    @(negedge clk);
    h.start = 1'b1;
    h.num_samples = SW'(num);
    @(negedge clk);
    h.start = 1'b0;
    n_cmp++; if (h.busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start got %b want 1", nm, h.busy); end
    for (int i = 0; i < NB; i++) begin
      if (i > 0) @(negedge clk);
      h.sample_valid = 1'b1;
      h.sample = BY'($urandom);
      h.start = poke && (i == 5);
      if (poke) h.num_samples = SW'(8);
    end
    foreach (smp[i]) begin
      @(negedge clk);
      h.start = 1'b0;
      h.sample_valid = 1'b1;
      h.sample = smp[i];
      b = smp[i][BY-1 -: HB];
      if (m[b] == 15) ovf = 1'b1; else m[b]++;
    end
    for (int i = 0; i < NB; i++) sb.push_back({HB'(i), CW'(m[i])});
    @(negedge clk);
    h.start = 1'b0;
    h.sample_valid = 1'b1;
    h.sample = 8'hF0;
    n_cmp++; if (h.rd_valid !== 1'b1) begin n_err++; $display("FAIL %s dump_start rd_valid got %b want 1", nm, h.rd_valid); end
    held = 1'b0;
    k = 0;
    bud = 0;
    while (sb.size() > 0 && bud < 200) begin
      if (bud > 0) @(negedge clk);
      bud++;
      h.sample_valid = 1'b1;
      h.sample = 8'hF0;
      if (held) begin
        n_cmp++;
        if (h.rd_bin !== hb || h.rd_count !== hc) begin
          n_err++;
          $display("FAIL %s hold got bin %0d cnt %0d want bin %0d cnt %0d", nm, h.rd_bin, h.rd_count, hb, hc);
        end
      end
      n_cmp++; if (h.rd_valid !== 1'b1) begin n_err++; $display("FAIL %s dump_valid got %b want 1 at entry %0d", nm, h.rd_valid, NB - sb.size()); end
      h.rd_ready = bp ? (k % 3 == 0) : 1'b1;
      k++;
      if (h.rd_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if ({h.rd_bin, h.rd_count} !== e) begin
          n_err++;
          $display("FAIL %s dump got bin %0d cnt %0d want bin %0d cnt %0d", nm, h.rd_bin, h.rd_count, e[HB+CW-1:CW], e[CW-1:0]);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        hb = h.rd_bin;
        hc = h.rd_count;
      end
    end
    if (sb.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s dump_timeout got %0d entries left want 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
    h.rd_ready = 1'b0;
    h.sample_valid = 1'b0;
    n_cmp++; if (h.done !== 1'b1) begin n_err++; $display("FAIL %s done_pulse got %b want 1", nm, h.done); end
    n_cmp++; if (h.busy !== 1'b0) begin n_err++; $display("FAIL %s busy_in_done got %b want 0", nm, h.busy); end
    n_cmp++; if (h.overflow !== ovf) begin n_err++; $display("FAIL %s overflow got %b want %b", nm, h.overflow, ovf); end
    @(negedge clk);
    n_cmp++; if (h.done !== 1'b0) begin n_err++; $display("FAIL %s done_width got %b want 0", nm, h.done); end
    n_cmp++; if (h.busy !== 1'b0) begin n_err++; $display("FAIL %s busy_idle got %b want 0", nm, h.busy); end
  endtask

  task automatic test_basic();
    q = '{8'h00, 8'h10, 8'h1F, 8'hF0};
    do_run("basic", 4, q, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    q = '{8'h00, 8'h10, 8'h1F, 8'hF0};
    do_run("backpressure", 4, q, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    q = {};
    repeat (20) q.push_back(8'h35);
    do_run("saturate", 20, q, 1'b0, 1'b0);
    q = '{8'h00, 8'h00};
    do_run("after_saturate", 2, q, 1'b0, 1'b0);
  endtask

  task automatic test_zero_length();
    q = {};
    do_run("zero_len", 0, q, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    h.start = 1'b1;
    h.num_samples = SW'(8);
    @(negedge clk);
    h.start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) @(negedge clk);
      h.sample_valid = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      h.sample_valid = 1'b1;
      h.sample = 8'h10;
    end
    @(negedge clk);
    h.sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (h.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", h.busy); end
    n_cmp++; if (h.rd_valid !== 1'b0) begin n_err++; $display("FAIL abort_rd_valid got %b want 0", h.rd_valid); end
    n_cmp++; if (h.done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", h.done); end
    n_cmp++; if (h.rd_count !== '0) begin n_err++; $display("FAIL abort_rd_count got %0d want 0", h.rd_count); end
    q = '{8'h10, 8'h2A, 8'h1C};
    do_run("post_abort", 3, q, 1'b0, 1'b1);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_zero_length();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rng_histogram.md
# rng_histogram

Downstream consumer of the `rng` stage: it takes the `rng`/`valid` sample stream and bins a programmed number of samples into 2^HB counters, then dumps the counts over a valid/ready read port. It sits after `rng` in the generator pipeline and is the on-chip distribution check for the generated samples.

## Interface
Parameters:
- BY, 8 — sample width; matches `RNG_BY` of the feeding `rng`.
- HB, 4 — histogram index bits; NB = 2^HB bins; HB <= BY is required.
- CW, 16 — per-bin counter width.
- SW, 16 — width of the sample-count request.

Ports:
- clk  in  1  — single clock; all logic updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begin a run; sampled only in IDLE.
- num_samples  in  SW  — number of samples to bin; latched when start is accepted.
- sample  in  BY  — connects to `rng`.
- sample_valid  in  1  — connects to `valid`; one sample per cycle while high.
- busy  out  1  — high in CLEAR, COLLECT and DUMP.
- done  out  1  — one-cycle pulse at end of run.
- overflow  out  1  — sticky; some bin saturated during this run.
- rd_bin  out  HB  — bin index being presented.
- rd_count  out  CW  — count of rd_bin.
- rd_valid  out  1  — dump entry valid.
- rd_ready  in  1  — consumer accepts the entry.

## Operation
- Bin index = sample[BY-1 -: HB], the top HB bits.
- States:
  - IDLE: start=1 latches num_samples and goes to CLEAR. overflow is cleared on this transition.
  - CLEAR: zero one counter per cycle, bin 0..NB-1. Takes NB cycles, then goes to COLLECT. If the latched num_samples = 0, go to DUMP instead.
  - COLLECT: each cycle with sample_valid=1, count[bin] += 1 and remaining -= 1.
    - If count[bin] = 2^CW-1, hold the count and set overflow.
    - Back-to-back valids to the same bin must each be counted. No lost increments.
    - When the sample that makes remaining = 0 is counted, go to DUMP.
  - DUMP: present bins 0..NB-1 in ascending order. Advance on rd_valid & rd_ready. After bin NB-1 is accepted, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- sample_valid is ignored outside COLLECT, and samples arriving then are dropped.
- start is ignored outside IDLE.
- Counters retain their values after DONE until the next run's CLEAR.
- Remaining-sample count is SW bits, unsigned. The maximum run is 2^SW-1 samples.

## Timing
- Reset: state=IDLE; busy, done, overflow, rd_valid = 0; rd_bin = 0; rd_count = 0. Counter contents are don't-care.
- Reset asserted in any state returns to IDLE on the next edge with the reset values above. The next start runs a fully clean histogram.
- Let start be sampled high at edge t:
  - CLEAR occupies cycles t+1 .. t+NB.
  - COLLECT begins at cycle t+NB+1.
  - busy=1 from cycle t+1.
- If the last sample is sampled at edge u:
  - DUMP begins at cycle u+1 with rd_valid=1, rd_bin=0, and rd_count reflecting that last increment.
- While rd_valid=1 and rd_ready=0, rd_bin and rd_count hold stable.
- With rd_ready tied high, DUMP lasts exactly NB cycles. done pulses the cycle after the last transfer.
- rd_valid does not depend combinationally on rd_ready.
- overflow is valid from the cycle after the saturating sample. It holds through DUMP and DONE until the next accepted start.

## Test plan
- Reset: hold rst 3 cycles with random inputs → busy=done=overflow=rd_valid=0, rd_bin=0, rd_count=0.
- Basic run (BY=8, HB=4): start, num_samples=4, samples 0x00,0x10,0x1F,0xF0 back-to-back, rd_ready=1 → CLEAR lasts 16 cycles. Dump gives bin0=1, bin1=2, bin15=1, all others 0, over 16 consecutive rd_valid cycles. Then a one-cycle done pulse; overflow=0.
- Backpressure: same run with rd_ready toggling 1,0,0,1,… → each entry is held stable until accepted. All 16 bins are delivered in order with none skipped or duplicated.
- Saturation (CW=4): 20 samples of 0x35.
  - Expected: bin3=15, overflow=1 through DONE.
  - Follow-up: a second run of 2 samples of 0x00 gives overflow=0, bin0=2, bin3=0.
- Zero length: num_samples=0 → CLEAR(16), then a dump of 16 zeros. sample_valid pulses during the run are ignored.
- Mid-run abort: assert rst in COLLECT after 2 of 8 samples → IDLE next edge with reset outputs. A start pulsed during busy in the following run is ignored, and that run counts exactly its own num_samples.
